// File: rtl/ata_pio_tctrl.sv
// OCIDEC-1 PIO compatible-timing engine: runs one ATA-3 PIO cycle per accepted
// request using programmed T1/T2/T4/Teoc counts, honouring IORDY wait states.
module ata_pio_tctrl #(
  parameter int TWIDTH   = 8,
  parameter int PIO_T1   = 6,
  parameter int PIO_T2   = 28,
  parameter int PIO_T4   = 2,
  parameter int PIO_TEOC = 23
) (
  input  logic              CLK_I,
  input  logic              nReset,
  input  logic              RST_I,
  input  logic              en,
  input  logic [TWIDTH-1:0] T1,
  input  logic [TWIDTH-1:0] T2,
  input  logic [TWIDTH-1:0] T4,
  input  logic [TWIDTH-1:0] Teoc,
  input  logic              IORDYen,
  input  logic              go,
  input  logic              we,
  input  logic [3:0]        A,
  input  logic [15:0]       D,
  output logic [15:0]       Q,
  output logic              done,
  output logic              busy,
  input  logic [15:0]       DDi,
  output logic [15:0]       DDo,
  output logic              DDoe,
  output logic [2:0]        DA,
  output logic              CS0n,
  output logic              CS1n,
  output logic              DIORn,
  output logic              DIOWn,
  input  logic              IORDY
);

  typedef enum logic [1:0] {ST_IDLE, ST_T1, ST_T2, ST_EOC} state_t;

  // T1 is consumed on the accept edge itself, so only T2/T4/Teoc need shadows.
  typedef struct packed {
    state_t            state;
    logic [TWIDTH-1:0] cnt;
    logic [TWIDTH-1:0] t4_cnt;
    logic [TWIDTH-1:0] t2_s;
    logic [TWIDTH-1:0] t4_s;
    logic [TWIDTH-1:0] teoc_s;
    logic              we_r;
    logic [2:0]        da;
    logic              cs0n;
    logic              cs1n;
    logic              diorn;
    logic              diown;
    logic [15:0]       ddo;
    logic              ddoe;
    logic [15:0]       q;
    logic              done;
    logic              busy;
  } regs_t;

  localparam regs_t R_RST = '{
    state:  ST_IDLE,
    cnt:    TWIDTH'(PIO_T1),
    t4_cnt: '0,
    t2_s:   TWIDTH'(PIO_T2),
    t4_s:   TWIDTH'(PIO_T4),
    teoc_s: TWIDTH'(PIO_TEOC),
    we_r:   1'b0,
    da:     3'd0,
    cs0n:   1'b1,
    cs1n:   1'b1,
    diorn:  1'b1,
    diown:  1'b1,
    ddo:    16'h0000,
    ddoe:   1'b0,
    q:      16'h0000,
    done:   1'b0,
    busy:   1'b0
  };

  regs_t       r;
  regs_t       n;
  logic [1:0]  iordy_sync;
  logic        iordy_s;
  logic [TWIDTH-1:0] eoc_len;

  // NOTE: the async reset owns the sensitivity list; RST_I is just a
  // synchronous override tested first inside the clocked branch.
  always_ff @(posedge CLK_I or negedge nReset) begin
    if (!nReset)    iordy_sync <= 2'b11;
    else if (RST_I) iordy_sync <= 2'b11;
    else            iordy_sync <= {iordy_sync[0], IORDY};
  end

  assign iordy_s = iordy_sync[1];
  assign eoc_len = (r.t4_s > r.teoc_s) ? r.t4_s : r.teoc_s;

  // NOTE: state is updated with <= only; the next-state logic below uses =.
  always_ff @(posedge CLK_I or negedge nReset) begin
    if (!nReset)    r <= R_RST;
    else if (RST_I) r <= R_RST;
    else            r <= n;
  end

  // NOTE: n starts as a copy of r so every field has a value on every path,
  // which keeps this block free of inferred latches.
  always_comb begin
    n      = r;
    n.done = 1'b0;
    case (r.state)
      ST_IDLE: begin
        if (go && en) begin
          n.t2_s   = T2;
          n.t4_s   = T4;
          n.teoc_s = Teoc;
          n.we_r   = we;
          n.da     = A[2:0];
          n.cs1n   = !A[3];
          n.cs0n   = A[3];
          n.busy   = 1'b1;
          if (we) begin
            n.ddo  = D;
            n.ddoe = 1'b1;
          end
          n.cnt   = T1;
          n.state = ST_T1;
        end
      end
      ST_T1: begin
        if (r.cnt == '0) begin
          n.cnt = r.t2_s;
          if (r.we_r) n.diown = 1'b0;
          else        n.diorn = 1'b0;
          n.state = ST_T2;
        end else begin
          n.cnt = r.cnt - 1'b1;
        end
      end
      ST_T2: begin
        if (r.cnt != '0) begin
          n.cnt = r.cnt - 1'b1;
        end else if (!IORDYen || iordy_s) begin
          n.diorn  = 1'b1;
          n.diown  = 1'b1;
          n.done   = 1'b1;
          if (!r.we_r) n.q = DDi;
          n.cnt    = eoc_len;
          n.t4_cnt = r.t4_s;
          n.state  = ST_EOC;
        end
        // Otherwise a wait state: counter parked at 0, strobe stays low.
      end
      ST_EOC: begin
        if (r.t4_cnt == '0) n.ddoe = 1'b0;
        else                n.t4_cnt = r.t4_cnt - 1'b1;
        if (r.cnt == '0) begin
          n.cs0n  = 1'b1;
          n.cs1n  = 1'b1;
          n.ddoe  = 1'b0;
          n.busy  = 1'b0;
          n.state = ST_IDLE;
        end else begin
          n.cnt = r.cnt - 1'b1;
        end
      end
      default: n = R_RST;
    endcase
  end

  assign Q     = r.q;
  assign done  = r.done;
  assign busy  = r.busy;
  assign DDo   = r.ddo;
  assign DDoe  = r.ddoe;
  assign DA    = r.da;
  assign CS0n  = r.cs0n;
  assign CS1n  = r.cs1n;
  assign DIORn = r.diorn;
  assign DIOWn = r.diown;

endmodule

// File: tb/tb_ata_pio_tctrl.sv
// Self-checking bench for ata_pio_tctrl: directed and randomized PIO cycles,
// compared each clock against an edge-timeline model derived from the timing rules.
module tb_ata_pio_tctrl;

  logic        CLK_I = 1'b0;
  logic        nReset = 1'b0;
  logic        RST_I = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  T1 = 8'd6, T2 = 8'd28, T4 = 8'd2, Teoc = 8'd23;
  logic        IORDYen = 1'b0;
  logic        go = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  A = 4'd0;
  logic [15:0] D = 16'd0;
  logic [15:0] Q;
  logic        done, busy;
  logic [15:0] DDi = 16'd0;
  logic [15:0] DDo;
  logic        DDoe;
  logic [2:0]  DA;
  logic        CS0n, CS1n, DIORn, DIOWn;
  logic        IORDY = 1'b1;

  int checks = 0;
  int failures = 0;
  int txn_no = 0;

  logic [15:0] q_model = 16'd0;
  logic [15:0] ddo_model = 16'd0;
  logic [2:0]  da_model = 3'd0;

  ata_pio_tctrl dut (
    .CLK_I(CLK_I), .nReset(nReset), .RST_I(RST_I), .en(en),
    .T1(T1), .T2(T2), .T4(T4), .Teoc(Teoc), .IORDYen(IORDYen),
    .go(go), .we(we), .A(A), .D(D), .Q(Q), .done(done), .busy(busy),
    .DDi(DDi), .DDo(DDo), .DDoe(DDoe), .DA(DA), .CS0n(CS0n), .CS1n(CS1n),
    .DIORn(DIORn), .DIOWn(DIOWn), .IORDY(IORDY)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic        we;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] ddi;
    int          t1, t2, t4, teoc;
    logic        iordyen;
    logic        waitm;     // hold IORDY low from the start
    int          wk;        // clocks past the first T2-zero check before IORDY rises
    logic        hold_go;   // keep go high until done
    logic        drop_en;   // drop en mid-cycle
    int          abort_at;  // edge at which RST_I is driven, -1 for none
  } txn_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] observed();
    return {CS0n, CS1n, DA, DIORn, DIOWn, DDoe, busy, done, Q, DDo};
  endfunction

  function automatic logic [41:0] idle_vec();
    return {1'b1, 1'b1, da_model, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, q_model, ddo_model};
  endfunction

  // Called just after a falling edge; the next rising edge is edge 0.
  task automatic run_txn(input txn_t t);
    int c0, dn, x, m, last;
    logic act, low;
    logic [41:0] exp_v;
    txn_no++;
    c0 = t.t1 + 1 + t.t2;       // edge on which T2 first reaches zero
    dn = c0 + 1;                 // done edge without wait states
    x  = c0 + 1 + t.wk;          // edge that first samples IORDY high
    if (t.waitm && t.iordyen) dn = x + 2;
    m    = (t.t4 > t.teoc) ? t.t4 : t.teoc;
    last = (t.abort_at >= 0) ? t.abort_at + 1 : dn + m + 3;
    we = t.we; A = t.a; D = t.d; DDi = t.ddi;
    T1 = 8'(t.t1); T2 = 8'(t.t2); T4 = 8'(t.t4); Teoc = 8'(t.teoc);
    IORDYen = t.iordyen; IORDY = !t.waitm; en = 1'b1; go = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(posedge CLK_I);
      @(negedge CLK_I);
      if (t.abort_at >= 0 && k == t.abort_at + 1) begin
        q_model = 16'd0; ddo_model = 16'd0; da_model = 3'd0;
        exp_v = idle_vec();
      end else begin
        act = (k <= dn + m);
        low = (k >= t.t1 + 1) && (k <= dn - 1);
        exp_v = {act ? t.a[3] : 1'b1, act ? !t.a[3] : 1'b1, t.a[2:0],
                 !(low && !t.we), !(low && t.we),
                 t.we && (k <= dn + t.t4), act, k == dn,
                 (!t.we && k >= dn) ? t.ddi : q_model,
                 t.we ? t.d : ddo_model};
      end
      check($sformatf("txn%0d_edge%0d", txn_no, k), 64'(observed()), 64'(exp_v));
      if (k == 0) begin
        if (!t.hold_go) go = 1'b0;
        T1 = 8'($urandom); T2 = 8'($urandom); T4 = 8'($urandom); Teoc = 8'($urandom);
      end
      if (t.hold_go && k == dn) go = 1'b0;
      if (t.waitm && k == x - 1) IORDY = 1'b1;
      if (t.drop_en && k == 2) en = 1'b0;
      if (k == dn) DDi = 16'($urandom);
      if (k == t.abort_at) RST_I = 1'b1;
    end
    RST_I = 1'b0; go = 1'b0; en = 1'b1; IORDY = 1'b1;
    if (t.abort_at < 0) begin
      da_model = t.a[2:0];
      if (t.we) ddo_model = t.d;
      else      q_model = t.ddi;
    end
  endtask

  function automatic txn_t base(input logic w, input logic [3:0] a, input logic [15:0] d,
                                input logic [15:0] ddi, input int t1, input int t2,
                                input int t4, input int teoc);
    txn_t t;
    t.we = w; t.a = a; t.d = d; t.ddi = ddi;
    t.t1 = t1; t.t2 = t2; t.t4 = t4; t.teoc = teoc;
    t.iordyen = 1'b0; t.waitm = 1'b0; t.wk = 0;
    t.hold_go = 1'b0; t.drop_en = 1'b0; t.abort_at = -1;
    return t;
  endfunction

  initial begin
    txn_t t;
    #12 nReset = 1'b1;
    @(negedge CLK_I);
    check("reset_state", 64'(observed()), 64'(idle_vec()));

    // Default timings, read
    run_txn(base(1'b0, 4'b0111, 16'h0, 16'h1234, 6, 28, 2, 23));
    // Write with T4 longer than Teoc
    run_txn(base(1'b1, 4'b1110, 16'hBEEF, 16'h0, 1, 3, 5, 2));
    // IORDY wait states honoured, then ignored
    t = base(1'b0, 4'b0011, 16'h0, 16'hA5A5, 2, 4, 1, 3);
    t.waitm = 1'b1; t.wk = 10; t.iordyen = 1'b1;
    run_txn(t);
    t.iordyen = 1'b0; t.ddi = 16'h5A5A;
    run_txn(t);
    // Synchronous reset mid-cycle, then a clean restart at edge 22
    t = base(1'b0, 4'b0111, 16'h0, 16'h7777, 6, 28, 2, 23);
    t.abort_at = 20;
    run_txn(t);
    run_txn(base(1'b1, 4'b0101, 16'hC0DE, 16'h0, 2, 2, 1, 1));
    // go held through done with Teoc = 0
    t = base(1'b0, 4'b1001, 16'h0, 16'h0F0F, 1, 2, 0, 0);
    t.hold_go = 1'b1;
    run_txn(t);
    // go while disabled: no activity
    en = 1'b0; go = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK_I);
      @(negedge CLK_I);
      check($sformatf("disabled_edge%0d", k), 64'(observed()), 64'(idle_vec()));
    end
    go = 1'b0; en = 1'b1;
    // All timings zero, read and write
    run_txn(base(1'b0, 4'b0000, 16'h0, 16'h8001, 0, 0, 0, 0));
    run_txn(base(1'b1, 4'b1111, 16'h1357, 16'h0, 0, 0, 0, 0));

    for (int i = 0; i < 30; i++) begin
      t = base(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 7), $urandom_range(0, 10),
               $urandom_range(0, 7), $urandom_range(0, 7));
      t.iordyen = 1'($urandom);
      t.waitm   = 1'($urandom);
      t.wk      = $urandom_range(0, 5);
      t.hold_go = 1'($urandom);
      t.drop_en = 1'($urandom);
      run_txn(t);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK_I);
        @(negedge CLK_I);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ata_pio_tctrl.md
Name: ata_pio_tctrl

Overview:
- PIO compatible-timing engine of the OCIDEC-1 ATA host controller.
- Sits directly downstream of the WISHBONE register/decoder stage. Takes one PIO request (address, write data, direction) plus the programmed T1/T2/T4/Teoc timing values.
- Drives the ATA bus (DA, CS0n/CS1n, DIORn/DIOWn, DD) through one complete ATA-3 PIO cycle, honouring IORDY.
- Returns read data and a one-cycle done pulse that the upstream stage uses as its acknowledge.

Parameters:
TWIDTH, 8, width of timing counters and timing inputs
PIO_T1, 6, reset value of the internal T1 shadow (70 ns @100 MHz)
PIO_T2, 28, reset value of the internal T2 shadow
PIO_T4, 2, reset value of the internal T4 shadow
PIO_TEOC, 23, reset value of the internal Teoc shadow

Ports:
CLK_I  in  1  master clock
nReset  in  1  asynchronous active-low reset
RST_I  in  1  synchronous active-high reset
en  in  1  controller enable (IDEen); go ignored when 0
T1  in  TWIDTH  address-setup count
T2  in  TWIDTH  strobe-active count
T4  in  TWIDTH  write-data-hold count
Teoc  in  TWIDTH  end-of-cycle count
IORDYen  in  1  honour IORDY wait states
go  in  1  level request from upstream decoder
we  in  1  1 = write, 0 = read
A  in  4  A[3] = CS1 select, A[2:0] = DA
D  in  16  write data
Q  out  16  read data
done  out  1  one-cycle completion pulse
busy  out  1  cycle in progress
DDi  in  16  ATA data in
DDo  out  16  ATA data out
DDoe  out  1  ATA data output enable
DA  out  3  ATA address
CS0n  out  1  command-block select
CS1n  out  1  control-block select
DIORn  out  1  read strobe
DIOWn  out  1  write strobe
IORDY  in  1  ATA ready (asynchronous)

Behaviour:
- Reset, nReset asynchronous and RST_I synchronous, identical effect:
  - State IDLE.
  - DIORn = DIOWn = CS0n = CS1n = 1.
  - DA = 0, DDo = 0, DDoe = 0.
  - Q = 0, done = 0, busy = 0.
  - Timing shadows loaded with the parameter values.
  - RST_I mid-cycle aborts the cycle immediately with these values; no done pulse.
- All bus outputs are registered.
- IORDY passes through a 2-flop synchronizer (IORDYs). Reset value of both flops is 1.
- Counters: a phase loaded with value N lasts N+1 clocks; it counts down and exits at 0. A value of 0 gives a 1-clock phase.
- IDLE:
  - On an edge with go & en, latch T1/T2/T4/Teoc into the shadows and latch A, D and we.
  - On the same edge: drive DA = A[2:0]; CS1n = !A[3]; CS0n = A[3]; busy = 1.
  - If we, DDo = D and DDoe = 1.
  - Load the counter with T1 and enter ST_T1.
- ST_T1: at count 0, load T2, drive the strobe low (DIOWn if we, else DIORn), enter ST_T2.
- ST_T2:
  - At count 0 with (!IORDYen | IORDYs): release the strobe, set done = 1 for one cycle, load EOC, enter ST_EOC.
  - For reads, Q <= DDi on that same edge.
  - At count 0 with IORDYen & !IORDYs: hold the counter at 0 and keep the strobe low (wait state). No timeout.
- ST_EOC:
  - Lasts max(T4, Teoc)+1 clocks.
  - DA, CS and DDo are held throughout.
  - DDoe drops after T4+1 clocks, tracked by a separate T4 counter.
  - At the end: CS0n = CS1n = 1, DDoe = 0, busy = 0, enter IDLE.
- go is ignored while busy. The upstream stage drops go in the cycle after done; because EOC is at least 1 clock, a stale go is never re-accepted.
- en dropping mid-cycle does not abort; the cycle completes normally.
- Timing input changes during a cycle have no effect until the next go.
- Q holds its value until the next completed read.

Test Plan:
- Default timings, read A = 4'b0111, DDi = 16'h1234, go at edge 0:
  - CS0n low edges 0..59, DA = 7.
  - DIORn low edges 7..35.
  - Edge 36: DIORn = 1, done = 1 for one cycle, Q = 16'h1234.
  - Idle at edge 60, busy low.
- Write A = 4'b1110, D = 16'hBEEF, T1 = 1, T2 = 3, T4 = 5, Teoc = 2:
  - CS1n low, DDoe = 1 from edge 0.
  - DIOWn low edges 2..5.
  - DDoe falls at edge 12; idle at edge 12 (EOC = 6 clocks).
- IORDYen = 1, IORDY held low 10 clocks into T2 count 0:
  - DIORn stays low 10+2 extra clocks (synchronizer latency), then completes with done.
  - Same stimulus with IORDYen = 0: no extension.
- RST_I asserted at edge 20 of a default read:
  - Edge 21: all strobes/CS high, DDoe = 0, no done.
  - A new go at edge 22 starts cleanly.
- go held high through done (upstream late), Teoc = 0:
  - Exactly one cycle executes per go acceptance.
  - go with en = 0: no bus activity, busy stays 0.
- All timings 0:
  - Cycle occupies 3 clocks (T1, T2, EOC of 1 each); done on the edge ending T2.
